rom_port_arbiter: RTL and testbench

//  Shares the single instruction ROM port between the fetch requester (IF) and a load requester (MEM).

---
 rtl/rom_port_arbiter_pkg.sv | 37 +++
 rtl/rom_port_arbiter_if.sv | 54 +++++
 rtl/rom_arb_prio.sv | 52 +++++
 rtl/rom_port_arbiter.sv | 102 ++++++++++
 tb/tb_rom_port_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rom_port_arbiter_pkg
//   Shared definitions for the instruction-ROM port arbiter:
//     owner_e         tag carried with each ROM beat (NONE / IF / MEM)
//     WAIT_W          width of the IF anti-starvation counter (MAX_WAIT <= 15)
//     rom_arb_wait_t  type of the anti-starvation counter
//     wait_next()     next value of the anti-starvation counter
// -----------------------------------------------------------------------------
package rom_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_IF   = 2'b01,
        OWN_MEM  = 2'b10
    } owner_e;

    localparam int WAIT_W = 4;

    typedef logic [WAIT_W-1:0] rom_arb_wait_t;

    // Counts consecutive cycles in which IF asks and is refused; saturates at
    // max_cnt and restarts from zero as soon as IF is served or stops asking.
    function automatic rom_arb_wait_t wait_next(input rom_arb_wait_t cnt,
                                                input rom_arb_wait_t max_cnt,
                                                input logic          if_denied);
        rom_arb_wait_t nxt;
        if (!if_denied) begin
            nxt = '0;
        end else if (cnt >= max_cnt) begin
            nxt = max_cnt;
        end else begin
            nxt = cnt + 1'b1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rom_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// rom_port_arbiter_if
//   Bundles the requester-side handshakes (IF fetch, MEM load), the ROM port
//   and the pipeline stall of the ROM port arbiter.
//   Modports:
//     slave   - the arbiter itself (takes requests, drives grants/data/ROM)
//     master  - the surroundings (requesters and the ROM)
//   Parameters: ADDR_W (ROM byte address width), DATA_W (ROM word width).
// -----------------------------------------------------------------------------
interface rom_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_flush_i;

    logic              mem_req_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic              mem_gnt_o;
    logic              mem_rvalid_o;
    logic [DATA_W-1:0] mem_rdata_o;

    logic              rom_ce_o;
    logic [ADDR_W-1:0] rom_addr_o;
    logic [DATA_W-1:0] rom_data_i;

    logic              stall_o;

    modport slave (
        input  if_req_i, if_addr_i, if_flush_i,
        input  mem_req_i, mem_addr_i,
        input  rom_data_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        output mem_gnt_o, mem_rvalid_o, mem_rdata_o,
        output rom_ce_o, rom_addr_o,
        output stall_o
    );

    modport master (
        output if_req_i, if_addr_i, if_flush_i,
        output mem_req_i, mem_addr_i,
        output rom_data_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        input  mem_gnt_o, mem_rvalid_o, mem_rdata_o,
        input  rom_ce_o, rom_addr_o,
        input  stall_o
    );

endinterface

// File: rtl/rom_arb_prio.sv
// -----------------------------------------------------------------------------
// rom_arb_prio
//   Combinational grant decision for the shared ROM port plus the IF
//   anti-starvation counter. MEM normally wins; once IF has been refused
//   MAX_WAIT cycles in a row it is forced through for one grant.
//   Ports:
//     clk       in   system clock
//     rst       in   asynchronous active-low reset
//     if_req    in   fetch request
//     mem_req   in   load request
//     if_gnt    out  fetch granted this cycle (combinational)
//     mem_gnt   out  load granted this cycle (combinational)
// -----------------------------------------------------------------------------
module rom_arb_prio
    import rom_port_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic mem_req,
    output logic if_gnt,
    output logic mem_gnt
);

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
        $error("rom_arb_prio: MAX_WAIT must be in 1..15");
    end

    localparam rom_arb_wait_t MAX_CNT = rom_arb_wait_t'(MAX_WAIT);

    rom_arb_wait_t wait_cnt;
    logic          force_if;

    // Grants are gated by reset so nothing is accepted while the pipeline is
    // held clear; a grant in reset would be silently lost.
    always_comb begin
        force_if = if_req && (wait_cnt == MAX_CNT);
        mem_gnt  = rst && mem_req && !force_if;
        if_gnt   = rst && if_req && !mem_gnt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_next(wait_cnt, MAX_CNT, if_req && !if_gnt);
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// -----------------------------------------------------------------------------
// rom_port_arbiter
//   Shares the single instruction ROM port between instruction fetch (IF) and
//   data loads (MEM). A grant in cycle N drives the registered ROM address in
//   N+1 and returns the owner-tagged word in N+2 (fixed latency 2, one grant
//   per cycle). IF is stalled whenever it requests and is not granted.
//   Ports:
//     clk   in      system clock, rising edge
//     rst   in      asynchronous active-low reset
//     bus   slave   rom_port_arbiter_if: IF/MEM handshakes, ROM port, stall
//   Parameters:
//     ADDR_W    ROM byte-address width (must match the interface)
//     DATA_W    ROM word width (must match the interface)
//     MAX_WAIT  consecutive IF refusals before IF is forced to win (1..15)
// -----------------------------------------------------------------------------
module rom_port_arbiter
    import rom_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    rom_port_arbiter_if.slave   bus
);

    logic              if_gnt;
    logic              mem_gnt;

    logic              rom_ce_q;
    logic [ADDR_W-1:0] rom_addr_q;
    owner_e            tag1_q;
    logic              if_rvalid_q;
    logic              mem_rvalid_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] mem_rdata_q;
    logic              if_beat_kept;

    rom_arb_prio #(
        .MAX_WAIT (MAX_WAIT)
    ) u_prio (
        .clk     (clk),
        .rst     (rst),
        .if_req  (bus.if_req_i),
        .mem_req (bus.mem_req_i),
        .if_gnt  (if_gnt),
        .mem_gnt (mem_gnt)
    );

    // A flush only kills the IF beat currently sitting on the ROM port; a
    // fetch granted in the same cycle is a fresh request and survives.
    assign if_beat_kept = (tag1_q == OWN_IF) && !bus.if_flush_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rom_ce_q     <= 1'b0;
            rom_addr_q   <= '0;
            tag1_q       <= OWN_NONE;
            if_rvalid_q  <= 1'b0;
            mem_rvalid_q <= 1'b0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
        end else begin
            // Stage 1: drive the ROM for whoever won this cycle.
            rom_ce_q <= if_gnt || mem_gnt;
            if (mem_gnt) begin
                rom_addr_q <= bus.mem_addr_i;
                tag1_q     <= OWN_MEM;
            end else if (if_gnt) begin
                rom_addr_q <= bus.if_addr_i;
                tag1_q     <= OWN_IF;
            end else begin
                tag1_q     <= OWN_NONE;
            end

            // Stage 2: capture the ROM word for its owner; data holds otherwise.
            if_rvalid_q  <= if_beat_kept;
            mem_rvalid_q <= (tag1_q == OWN_MEM);
            if (if_beat_kept) begin
                if_rdata_q <= bus.rom_data_i;
            end
            if (tag1_q == OWN_MEM) begin
                mem_rdata_q <= bus.rom_data_i;
            end
        end
    end

    assign bus.if_gnt_o     = if_gnt;
    assign bus.mem_gnt_o    = mem_gnt;
    assign bus.stall_o      = bus.if_req_i & ~if_gnt;
    assign bus.rom_ce_o     = rom_ce_q;
    assign bus.rom_addr_o   = rom_addr_q;
    assign bus.if_rvalid_o  = if_rvalid_q;
    assign bus.if_rdata_o   = if_rdata_q;
    assign bus.mem_rvalid_o = mem_rvalid_q;
    assign bus.mem_rdata_o  = mem_rdata_q;

    a_single_gnt : assert property (@(posedge clk) disable iff (!rst)
                                    !(if_gnt && mem_gnt));

endmodule

// File: tb/tb_rom_port_arbiter.sv
module tb_rom_port_arbiter;

    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    rom_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    rom_port_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'hB000_0000 ^ {2'b00, a[31:2]};
    endfunction

    assign bus.rom_data_i = rom_word(bus.rom_addr_o);

    int checks   = 0;
    int failures = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (cycle-numbered beat list) ----------------
    typedef struct {
        logic        is_if;
        logic [31:0] addr;
        int          gcyc;
    } beat_t;

    beat_t       inflight[$];
    int          cyc;
    int          streak;
    int          last_gcyc;
    logic [31:0] last_gaddr;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_mem_rdata;
    logic        m_ig;
    logic        m_mg;

    task automatic model_reset();
        cyc           = 0;
        streak        = 0;
        last_gcyc     = -100;
        last_gaddr    = '0;
        exp_if_rdata  = '0;
        exp_mem_rdata = '0;
        inflight.delete();
    endtask

    // One clock cycle: drive inputs just after the rising edge, check every
    // output against the model at the falling edge, then advance the model.
    task automatic step(input logic ifr, input logic [31:0] ifa,
                        input logic memr, input logic [31:0] mema, input logic fl);
        logic  e_irv;
        logic  e_mrv;
        logic  e_ce;
        beat_t b;
        @(posedge clk);
        #1;
        bus.if_req_i   = ifr;
        bus.if_addr_i  = ifa;
        bus.mem_req_i  = memr;
        bus.mem_addr_i = mema;
        bus.if_flush_i = fl;
        cyc++;

        m_mg = memr && !(ifr && streak >= MAX_WAIT);
        m_ig = ifr && !m_mg;

        e_irv = 1'b0;
        e_mrv = 1'b0;
        while (inflight.size() > 0 && inflight[0].gcyc < cyc - 2) begin
            void'(inflight.pop_front());
        end
        if (inflight.size() > 0 && inflight[0].gcyc == cyc - 2) begin
            b = inflight.pop_front();
            if (b.is_if) begin
                e_irv        = 1'b1;
                exp_if_rdata = rom_word(b.addr);
            end else begin
                e_mrv         = 1'b1;
                exp_mem_rdata = rom_word(b.addr);
            end
        end
        e_ce = (last_gcyc == cyc - 1);

        @(negedge clk);
        chk1 ("model if_gnt",     bus.if_gnt_o,     m_ig);
        chk1 ("model mem_gnt",    bus.mem_gnt_o,    m_mg);
        chk1 ("model stall",      bus.stall_o,      ifr && !m_ig);
        chk1 ("model rom_ce",     bus.rom_ce_o,     e_ce);
        chk32("model rom_addr",   bus.rom_addr_o,   last_gaddr);
        chk1 ("model if_rvalid",  bus.if_rvalid_o,  e_irv);
        chk1 ("model mem_rvalid", bus.mem_rvalid_o, e_mrv);
        chk32("model if_rdata",   bus.if_rdata_o,   exp_if_rdata);
        chk32("model mem_rdata",  bus.mem_rdata_o,  exp_mem_rdata);

        if (ifr && !m_ig) streak = (streak < MAX_WAIT) ? streak + 1 : MAX_WAIT;
        else              streak = 0;
        if (fl) begin
            for (int i = inflight.size() - 1; i >= 0; i--) begin
                if (inflight[i].is_if && inflight[i].gcyc == cyc - 1) inflight.delete(i);
            end
        end
        if (m_ig || m_mg) begin
            b.is_if    = m_ig;
            b.addr     = m_ig ? ifa : mema;
            b.gcyc     = cyc;
            inflight.push_back(b);
            last_gcyc  = cyc;
            last_gaddr = b.addr;
        end
    endtask

    // Reset with both requests asserted: nothing granted, all outputs cleared.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst            = 1'b0;
        bus.if_req_i   = 1'b1;
        bus.if_addr_i  = 32'h40;
        bus.mem_req_i  = 1'b1;
        bus.mem_addr_i = 32'h300;
        bus.if_flush_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk1 ("rst if_gnt",     bus.if_gnt_o,     1'b0);
            chk1 ("rst mem_gnt",    bus.mem_gnt_o,    1'b0);
            chk1 ("rst rom_ce",     bus.rom_ce_o,     1'b0);
            chk32("rst rom_addr",   bus.rom_addr_o,   32'h0);
            chk1 ("rst if_rvalid",  bus.if_rvalid_o,  1'b0);
            chk1 ("rst mem_rvalid", bus.mem_rvalid_o, 1'b0);
            chk32("rst if_rdata",   bus.if_rdata_o,   32'h0);
            chk32("rst mem_rdata",  bus.mem_rdata_o,  32'h0);
        end
        #1;
        bus.if_req_i  = 1'b0;
        bus.mem_req_i = 1'b0;
        rst           = 1'b1;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        ifr;
        logic [31:0] ifa;
        logic        memr;
        logic [31:0] mema;
        logic        fl;
        logic        e_ig;
        logic        e_mg;
        logic        e_st;
        logic        e_ce;
        logic        e_irv;
        logic        e_mrv;
        logic [31:0] e_data;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic ifr, input logic [31:0] ifa,
                                input logic memr, input logic [31:0] mema, input logic fl,
                                input logic ig, input logic mg, input logic st, input logic ce,
                                input logic irv, input logic mrv, input logic [31:0] data);
        vec_t v;
        v.ifr = ifr;  v.ifa = ifa;  v.memr = memr; v.mema = mema; v.fl = fl;
        v.e_ig = ig;  v.e_mg = mg;  v.e_st = st;   v.e_ce = ce;
        v.e_irv = irv; v.e_mrv = mrv; v.e_data = data;
        return v;
    endfunction

    logic        if_pend;
    logic        mem_pend;
    logic [31:0] if_a;
    logic [31:0] mem_a;
    logic        fl_r;

    initial begin
        //                ifr ifa      memr mema     fl  ig mg st ce irv mrv data
        // IF-only stream, latency 2
        tbl.push_back(mk(1, 32'h000, 0, 32'h000, 0,  1, 0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(1, 32'h004, 0, 32'h000, 0,  1, 0, 0, 1, 0, 0, 32'h0));
        tbl.push_back(mk(1, 32'h008, 0, 32'h000, 0,  1, 0, 0, 1, 1, 0, rom_word(32'h000)));
        tbl.push_back(mk(0, 32'h000, 0, 32'h000, 0,  0, 0, 0, 1, 1, 0, rom_word(32'h004)));
        tbl.push_back(mk(0, 32'h000, 0, 32'h000, 0,  0, 0, 0, 0, 1, 0, rom_word(32'h008)));
        // collision: MEM first, IF next cycle
        tbl.push_back(mk(1, 32'h00C, 1, 32'h100, 0,  0, 1, 1, 0, 0, 0, 32'h0));
        tbl.push_back(mk(1, 32'h00C, 0, 32'h000, 0,  1, 0, 0, 1, 0, 0, 32'h0));
        tbl.push_back(mk(0, 32'h000, 0, 32'h000, 0,  0, 0, 0, 1, 0, 1, rom_word(32'h100)));
        tbl.push_back(mk(0, 32'h000, 0, 32'h000, 0,  0, 0, 0, 0, 1, 0, rom_word(32'h00C)));
        // starvation: IF refused four times, forced on the fifth
        tbl.push_back(mk(1, 32'h010, 1, 32'h104, 0,  0, 1, 1, 0, 0, 0, 32'h0));
        tbl.push_back(mk(1, 32'h010, 1, 32'h108, 0,  0, 1, 1, 1, 0, 0, 32'h0));
        tbl.push_back(mk(1, 32'h010, 1, 32'h10C, 0,  0, 1, 1, 1, 0, 1, rom_word(32'h104)));
        tbl.push_back(mk(1, 32'h010, 1, 32'h110, 0,  0, 1, 1, 1, 0, 1, rom_word(32'h108)));
        tbl.push_back(mk(1, 32'h010, 1, 32'h114, 0,  1, 0, 0, 1, 0, 1, rom_word(32'h10C)));
        tbl.push_back(mk(0, 32'h000, 1, 32'h114, 0,  0, 1, 0, 1, 0, 1, rom_word(32'h110)));
        tbl.push_back(mk(0, 32'h000, 0, 32'h000, 0,  0, 0, 0, 1, 1, 0, rom_word(32'h010)));
        tbl.push_back(mk(0, 32'h000, 0, 32'h000, 0,  0, 0, 0, 0, 0, 1, rom_word(32'h114)));
        // flush while the beat is on the ROM port: dropped
        tbl.push_back(mk(1, 32'h020, 0, 32'h000, 0,  1, 0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 32'h000, 0, 32'h000, 1,  0, 0, 0, 1, 0, 0, 32'h0));
        tbl.push_back(mk(0, 32'h000, 0, 32'h000, 0,  0, 0, 0, 0, 0, 0, 32'h0));
        // flush in the rvalid cycle: still delivered
        tbl.push_back(mk(1, 32'h024, 0, 32'h000, 0,  1, 0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 32'h000, 0, 32'h000, 0,  0, 0, 0, 1, 0, 0, 32'h0));
        tbl.push_back(mk(0, 32'h000, 0, 32'h000, 1,  0, 0, 0, 0, 1, 0, rom_word(32'h024)));
        // flush together with a new IF request: the new request survives
        tbl.push_back(mk(1, 32'h028, 0, 32'h000, 1,  1, 0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 32'h000, 0, 32'h000, 0,  0, 0, 0, 1, 0, 0, 32'h0));
        tbl.push_back(mk(0, 32'h000, 0, 32'h000, 0,  0, 0, 0, 0, 1, 0, rom_word(32'h028)));
        // flush never drops a MEM beat
        tbl.push_back(mk(0, 32'h000, 1, 32'h200, 0,  0, 1, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 32'h000, 0, 32'h000, 1,  0, 0, 0, 1, 0, 0, 32'h0));
        tbl.push_back(mk(0, 32'h000, 0, 32'h000, 0,  0, 0, 0, 0, 0, 1, rom_word(32'h200)));

        bus.if_req_i   = 1'b0;
        bus.if_addr_i  = '0;
        bus.mem_req_i  = 1'b0;
        bus.mem_addr_i = '0;
        bus.if_flush_i = 1'b0;
        model_reset();

        do_reset();

        foreach (tbl[i]) begin
            step(tbl[i].ifr, tbl[i].ifa, tbl[i].memr, tbl[i].mema, tbl[i].fl);
            chk1($sformatf("v%0d if_gnt", i),     bus.if_gnt_o,     tbl[i].e_ig);
            chk1($sformatf("v%0d mem_gnt", i),    bus.mem_gnt_o,    tbl[i].e_mg);
            chk1($sformatf("v%0d stall", i),      bus.stall_o,      tbl[i].e_st);
            chk1($sformatf("v%0d rom_ce", i),     bus.rom_ce_o,     tbl[i].e_ce);
            chk1($sformatf("v%0d if_rvalid", i),  bus.if_rvalid_o,  tbl[i].e_irv);
            chk1($sformatf("v%0d mem_rvalid", i), bus.mem_rvalid_o, tbl[i].e_mrv);
            if (tbl[i].e_irv) chk32($sformatf("v%0d if_rdata", i),  bus.if_rdata_o,  tbl[i].e_data);
            if (tbl[i].e_mrv) chk32($sformatf("v%0d mem_rdata", i), bus.mem_rdata_o, tbl[i].e_data);
        end

        // Reset one cycle after a MEM grant: ROM enable drops at once, no rvalid.
        step(1'b0, 32'h0, 1'b1, 32'h300, 1'b0);
        chk1("midrst grant", bus.mem_gnt_o, 1'b1);
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.mem_req_i = 1'b0;
        @(negedge clk);
        chk1("midrst rom_ce",     bus.rom_ce_o,     1'b0);
        chk1("midrst mem_rvalid", bus.mem_rvalid_o, 1'b0);
        @(negedge clk);
        chk1("midrst mem_rvalid2", bus.mem_rvalid_o, 1'b0);
        #1;
        rst = 1'b1;
        model_reset();

        // Randomized traffic: requests hold their address until granted.
        if_pend  = 1'b0;
        mem_pend = 1'b0;
        if_a     = '0;
        mem_a    = '0;
        for (int n = 0; n < 600; n++) begin
            if (!if_pend && $urandom_range(0, 99) < 55) begin
                if_pend = 1'b1;
                if_a    = 32'($urandom_range(0, 1023)) << 2;
            end
            if (!mem_pend && $urandom_range(0, 99) < 70) begin
                mem_pend = 1'b1;
                mem_a    = 32'h8000 + (32'($urandom_range(0, 1023)) << 2);
            end
            fl_r = ($urandom_range(0, 7) == 0);
            step(if_pend, if_a, mem_pend, mem_a, fl_r);
            if (m_ig) if_pend  = 1'b0;
            if (m_mg) mem_pend = 1'b0;
        end

        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
